// File: rtl/seq_ckt_pkg.sv
// Shared definitions for the sequential-circuit job scheduler: state encoding
// and the default widths of the hold-length counter and the Z capture register.
package seq_ckt_pkg;

   localparam int CNT_W_DEF = 4;

   // The capture register must hold one sample for each of the 2**CNT_W DRIVE cycles.
   function automatic int cap_w(input int cnt_w);
      return 2 ** cnt_w;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRIVE = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

endpackage

// File: rtl/seq_ckt_sched_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the requester served last
// and changes only when the owner of the current grant is actually accepted.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_q;
   logic last_d;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
      last_d = advance ? grant[1] : last_q;
   end

   // Reset value 1 marks requester 1 as last served, so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/seq_ckt_sched.sv
// Schedules jobs from two requesters onto one shared sequential circuit: it resets
// the circuit, holds a job's {A,B,C} vector for len+1 cycles, and returns the Z history.
module seq_ckt_sched
   import seq_ckt_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int CAP_W = cap_w(CNT_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [2:0]       req_abc0,
   input  logic [2:0]       req_abc1,
   input  logic [CNT_W-1:0] req_len0,
   input  logic [CNT_W-1:0] req_len1,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [CAP_W-1:0] rsp_z,
   output logic             dp_a,
   output logic             dp_b,
   output logic             dp_c,
   output logic             dp_rst,
   input  logic             dp_z,
   output logic [1:0]       dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
   // req_ready is the only combinational output; everything else comes from a flop.

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [2:0]       abc_q, abc_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             id_q, id_d;
   logic [CAP_W-1:0] z_q, z_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             dp_rst_q, dp_rst_d;
   logic [2:0]       dp_abc_q, dp_abc_d;

   logic [1:0] grant;
   logic       transfer;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst),
      .req     (req_valid),
      .advance (transfer),
      .grant   (grant)
   );

   assign req_ready = (state_q == ST_IDLE) ? grant : 2'b00;
   assign transfer  = |(req_valid & req_ready);

   always_comb begin
      state_d = state_q;
      abc_d   = abc_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
      z_d     = z_q;
      case (state_q)
         ST_IDLE: begin
            if (transfer) begin
               abc_d   = grant[1] ? req_abc1 : req_abc0;
               len_d   = grant[1] ? req_len1 : req_len0;
               id_d    = grant[1];
               z_d     = '0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            cnt_d   = len_q;
            state_d = ST_DRIVE;
         end
         ST_DRIVE: begin
            z_d = {z_q[CAP_W-2:0], dp_z};
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Output flops are loaded from the next state so they line up with state_q.
      rsp_valid_d = (state_d == ST_RESP);
      dp_rst_d    = (state_d != ST_DRIVE);
      dp_abc_d    = ((state_d == ST_LOAD) || (state_d == ST_DRIVE)) ? abc_d : 3'b000;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         abc_q       <= 3'b000;
         len_q       <= '0;
         cnt_q       <= '0;
         id_q        <= 1'b0;
         z_q         <= '0;
         rsp_valid_q <= 1'b0;
         dp_rst_q    <= 1'b1;
         dp_abc_q    <= 3'b000;
      end else begin
         state_q     <= state_d;
         abc_q       <= abc_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         id_q        <= id_d;
         z_q         <= z_d;
         rsp_valid_q <= rsp_valid_d;
         dp_rst_q    <= dp_rst_d;
         dp_abc_q    <= dp_abc_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = id_q;
   assign rsp_z     = z_q;
   assign dp_rst    = dp_rst_q;
   assign dp_a      = dp_abc_q[2];
   assign dp_b      = dp_abc_q[1];
   assign dp_c      = dp_abc_q[0];
   assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_ckt_sched.sv
// Bench for seq_ckt_sched: a job-level reference model predicts grants, dp_* activity,
// response timing and Z history; a scripted dp_z stub feeds the sampled bits.
module tb_seq_ckt_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [2:0]  req_abc0, req_abc1;
   logic [3:0]  req_len0, req_len1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [15:0] rsp_z;
   logic        dp_a, dp_b, dp_c, dp_rst;
   logic        dp_z;
   logic [1:0]  dbg_state;

   seq_ckt_sched dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_abc0  (req_abc0),
      .req_abc1  (req_abc1),
      .req_len0  (req_len0),
      .req_len1  (req_len1),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_z     (rsp_z),
      .dp_a      (dp_a),
      .dp_b      (dp_b),
      .dp_c      (dp_c),
      .dp_rst    (dp_rst),
      .dp_z      (dp_z),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model: one job in flight, k = cycles since the accepting edge
   logic [16:0] exp_q[$];
   int          acc_ids[$];
   int          acc_cycs[$];
   bit          script_q[$];
   bit          all_ones = 1'b0;
   bit          in_flight = 1'b0;
   int          k, j_len, cyc = 0, acc_cyc = 0;
   logic [2:0]  j_abc;
   logic        j_id;
   logic [15:0] j_z;
   bit          bits[16];
   logic        rr_last = 1'b1;
   int          acc_cnt = 0, resp_cnt = 0;
   logic [15:0] last_rsp_z;
   logic        last_rsp_id;
   int          last_lat;

   function automatic logic [1:0] rr_pick(input logic [1:0] v, input logic last);
      if (v == 2'b11) return last ? 2'b01 : 2'b10;
      return v;
   endfunction

   always @(negedge clk) begin
      logic [1:0]  g;
      logic [16:0] e;
      cyc++;
      dp_z = 1'($urandom_range(0, 1));
      if (!rst) begin
         check("rst_rsp_valid", rsp_valid, 1'b0);
         check("rst_dp_rst", dp_rst, 1'b1);
         check("rst_dp_abc", {dp_a, dp_b, dp_c}, 3'b000);
         check("rst_req_ready", req_ready, 2'b00);
         check("rst_rsp_z", rsp_z, 16'h0000);
         check("rst_rsp_id", rsp_id, 1'b0);
         in_flight = 1'b0;
         rr_last   = 1'b1;
         exp_q.delete();
      end else if (in_flight) begin
         check("busy_req_ready", req_ready, 2'b00);
         if (k == 0) begin
            check("load_dp_rst", dp_rst, 1'b1);
            check("load_dp_abc", {dp_a, dp_b, dp_c}, j_abc);
            check("load_rsp_valid", rsp_valid, 1'b0);
         end else if (k <= j_len + 1) begin
            check("drive_dp_rst", dp_rst, 1'b0);
            check("drive_dp_abc", {dp_a, dp_b, dp_c}, j_abc);
            check("drive_rsp_valid", rsp_valid, 1'b0);
            dp_z = bits[k-1];
         end else begin
            check("resp_valid", rsp_valid, 1'b1);
            check("resp_dp_rst", dp_rst, 1'b1);
            check("resp_dp_abc", {dp_a, dp_b, dp_c}, 3'b000);
            check("resp_id", rsp_id, j_id);
            check("resp_z", rsp_z, j_z);
            if (k == j_len + 2) begin
               check("sb_count", exp_q.size(), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("sb_id", rsp_id, e[16]);
                  check("sb_z", rsp_z, e[15:0]);
               end
               last_rsp_z  = rsp_z;
               last_rsp_id = rsp_id;
               last_lat    = cyc - acc_cyc;
            end
         end
         if (k >= j_len + 2 && rsp_ready) begin
            in_flight = 1'b0;
            resp_cnt++;
         end else begin
            k++;
         end
      end else begin
         check("idle_rsp_valid", rsp_valid, 1'b0);
         check("idle_dp_rst", dp_rst, 1'b1);
         check("idle_dp_abc", {dp_a, dp_b, dp_c}, 3'b000);
         g = rr_pick(req_valid, rr_last);
         check("idle_req_ready", req_ready, g);
         if (g != 2'b00) begin
            j_id  = g[1];
            j_abc = j_id ? req_abc1 : req_abc0;
            j_len = int'(j_id ? req_len1 : req_len0);
            j_z   = 16'h0000;
            for (int i = 0; i <= j_len; i++) begin
               if (script_q.size() > 0) bits[i] = script_q.pop_front();
               else if (all_ones)       bits[i] = 1'b1;
               else                     bits[i] = 1'($urandom_range(0, 1));
               j_z = {j_z[14:0], bits[i]};
            end
            exp_q.push_back({j_id, j_z});
            acc_ids.push_back(int'(j_id));
            acc_cyc = cyc + 1;
            acc_cycs.push_back(acc_cyc);
            rr_last   = j_id;
            in_flight = 1'b1;
            k         = 0;
            acc_cnt++;
         end
      end
   end

   // driver tasks: inputs change 2 time units after the rising edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input int id, input logic [2:0] abc, input logic [3:0] len);
      int a0 = acc_cnt;
      bit got = 1'b0;
      if (id == 0) begin req_abc0 = abc; req_len0 = len; end
      else         begin req_abc1 = abc; req_len1 = len; end
      req_valid[id] = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         if (acc_cnt != a0) got = 1'b1;
      end
      req_valid[id] = 1'b0;
      check("accept_seen", got, 1'b1);
   endtask

   task automatic wait_idle(input int bound);
      bit ok = 1'b0;
      for (int i = 0; i < bound && !ok; i++) begin
         tick();
         if (!in_flight) ok = 1'b1;
      end
      check("idle_reached", ok, 1'b1);
   endtask

   task automatic do_reset();
      req_valid = 2'b00;
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
   endtask

   initial begin
      int r0;
      bit hit;
      rst = 1'b0;
      req_valid = 2'b00;
      req_abc0 = 3'b000; req_abc1 = 3'b000;
      req_len0 = 4'd0;   req_len1 = 4'd0;
      rsp_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      tick();

      // single job with scripted Z samples 1,0,1,1
      script_q = '{1'b1, 1'b0, 1'b1, 1'b1};
      send(0, 3'b011, 4'd3);
      wait_idle(40);
      check("single_z", last_rsp_z, 16'h000B);
      check("single_id", last_rsp_id, 1'b0);
      check("single_lat", last_lat, 5);

      // maximum hold length, Z stuck high
      all_ones = 1'b1;
      send(1, 3'b100, 4'd15);
      wait_idle(60);
      all_ones = 1'b0;
      check("max_z", last_rsp_z, 16'hFFFF);
      check("max_lat", last_lat, 17);

      // reset during the third DRIVE cycle discards the job
      r0 = resp_cnt;
      send(0, 3'b011, 4'd7);
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         if (in_flight && k == 3) hit = 1'b1;
         else tick();
      end
      check("abort_reached", hit, 1'b1);
      do_reset();
      check("abort_no_rsp", resp_cnt, r0);
      send(0, 3'b110, 4'd2);
      wait_idle(40);
      check("after_abort_rsp", resp_cnt, r0 + 1);

      // contention, len 0, rsp_ready tied high
      do_reset();
      acc_ids.delete();
      acc_cycs.delete();
      req_len0 = 4'd0; req_len1 = 4'd0;
      req_abc0 = 3'b101; req_abc1 = 3'b010;
      req_valid = 2'b11;
      repeat (20) tick();
      req_valid = 2'b00;
      wait_idle(20);
      check("cont_count", acc_ids.size() >= 4, 1'b1);
      for (int i = 0; i < 4 && i < acc_ids.size(); i++) check("cont_id", acc_ids[i], i % 2);
      if (acc_cycs.size() >= 2) check("cont_gap", acc_cycs[1] - acc_cycs[0], 4);

      // backpressure: hold rsp_ready low for 10 cycles while requester 1 waits
      rsp_ready = 1'b0;
      send(0, 3'b001, 4'd5);
      hit = 1'b0;
      for (int i = 0; i < 30 && !hit; i++) begin
         tick();
         if (rsp_valid) hit = 1'b1;
      end
      check("bp_rsp_seen", hit, 1'b1);
      req_abc1 = 3'b010; req_len1 = 4'd2;
      req_valid = 2'b10;
      for (int i = 0; i < 10; i++) begin
         check("bp_valid_held", rsp_valid, 1'b1);
         check("bp_no_ready", req_ready, 2'b00);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("bp_exit_valid", rsp_valid, 1'b0);
      check("bp_idle_ready", req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      wait_idle(40);

      // randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         req_valid = 2'($urandom_range(0, 3));
         req_abc0  = 3'($urandom_range(0, 7));
         req_abc1  = 3'($urandom_range(0, 7));
         req_len0  = 4'($urandom_range(0, 15));
         req_len1  = 4'($urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 299) == 0) do_reset();
         else tick();
      end
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      wait_idle(40);
      check("sb_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
